// File: rtl/nios_v1_key_pio_pkg.sv
// nios_v1_key_pio_pkg: register map addresses and edge-capture mode encodings
package nios_v1_key_pio_pkg;
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;
   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;
endpackage

// File: rtl/nios_v1_key_pio_edge_detect.sv
// pio_edge_detect: input synchronizer, delay flop and registered per-bit edge pulse
module pio_edge_detect
   import nios_v1_key_pio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int EDGE_TYPE   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] edge_pulse
);
   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] dly;
   logic [WIDTH-1:0] edge_raw;
   logic [2:0] prime_cnt;
   logic primed;

   assign data   = sync_q[SYNC_STAGES-1];
   assign primed = prime_cnt == 3'(SYNC_STAGES + 1);

   // edge select on synchronized values only
   always_comb edge_raw = EDGE_TYPE == EDGE_RISING  ? data & ~dly :
                          EDGE_TYPE == EDGE_FALLING ? ~data & dly : data ^ dly;

   // synchronizer shift, delay flop, and pulse gated until the chain is primed after reset
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         sync_q     <= '0;
         dly        <= '0;
         prime_cnt  <= '0;
         edge_pulse <= '0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], in_port};
         dly        <= data;
         prime_cnt  <= primed ? prime_cnt : prime_cnt + 3'd1;
         edge_pulse <= primed ? edge_raw : '0;
      end
endmodule

// File: rtl/nios_v1_key_pio.sv
// nios_v1_key_pio: Avalon-MM parallel input port with edge capture and maskable interrupt
module nios_v1_key_pio
   import nios_v1_key_pio_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int EDGE_TYPE   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   logic [WIDTH-1:0] data, edge_pulse, edgecap, irqmask, wr_bits, clr_bits, rd_sel;
   logic wr, rd, unused_wdata;

   assign wr           = chipselect & ~write_n;
   assign rd           = chipselect & write_n;
   assign wr_bits      = writedata[WIDTH-1:0];
   assign unused_wdata = ^writedata;
   assign irq          = |(edgecap & irqmask);

   pio_edge_detect #(
      .WIDTH(WIDTH), .EDGE_TYPE(EDGE_TYPE), .SYNC_STAGES(SYNC_STAGES)
   ) u_edge (
      .clk(clk), .reset_n(reset_n), .in_port(in_port), .data(data), .edge_pulse(edge_pulse)
   );

   // read mux and write-1-to-clear mask for the capture register
   always_comb begin
      rd_sel   = address == ADDR_DATA    ? data :
                 address == ADDR_IRQMASK ? irqmask :
                 address == ADDR_EDGECAP ? edgecap : '0;
      clr_bits = (wr && address == ADDR_EDGECAP) ? wr_bits : '0;
   end

   // register file: capture (new edges win over clears), mask load, registered read data
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         edgecap  <= '0;
         irqmask  <= '0;
         readdata <= '0;
      end else begin
         edgecap <= (edgecap & ~clr_bits) | edge_pulse;
         if (wr && address == ADDR_IRQMASK) irqmask <= wr_bits;
         if (rd) readdata <= 32'(rd_sel);
      end
endmodule

// File: tb/tb_nios_v1_key_pio.sv
// tb_nios_v1_key_pio: directed and randomized checks against a behavioural register model
module tb_nios_v1_key_pio;
   localparam int W = 8;
   localparam int S = 2;

   logic clk = 0;
   logic reset_n;
   logic [1:0] address;
   logic chipselect, write_n;
   logic [31:0] writedata, readdata;
   logic [W-1:0] in_port;
   logic irq;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] m_pin, m_cap, m_mask;

   nios_v1_key_pio #(.WIDTH(W), .EDGE_TYPE(1), .SYNC_STAGES(S)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk);
      #1 address = a; writedata = d; chipselect = 1; write_n = 0;
      @(posedge clk);
      #1 chipselect = 0; write_n = 1; writedata = $urandom;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
      @(posedge clk);
      #1 address = a; chipselect = 1; write_n = 1;
      @(posedge clk);
      #1 chipselect = 0; v = readdata;
   endtask

   task automatic settle();
      repeat (S + 4) @(posedge clk);
      #1;
   endtask

   task automatic set_pin(input logic [W-1:0] v);
      @(posedge clk);
      #1 in_port = v;
      m_cap = m_cap | (m_pin & ~v);
      m_pin = v;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      reset_n = 0; chipselect = 0; write_n = 1; address = 0; writedata = 0; in_port = 8'hFF;
      #1;
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h want 0", readdata); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
      repeat (3) @(posedge clk);
      #1 reset_n = 1;
      settle();
      m_pin = 8'hFF; m_cap = 0; m_mask = 0;
      bus_read(0, v);
      checks++; if (v !== 32'h000000FF) begin errors++; $display("FAIL reset_data got %h want 000000ff", v); end
      bus_read(2, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_mask got %h want 0", v); end
      bus_read(3, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_nocapture got %h want 0", v); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq_after got %b want 0", irq); end
   endtask

   task automatic test_irq_latency();
      logic [31:0] v;
      bus_write(2, 32'h1); m_mask = 8'h01;
      set_pin(8'hFE);
      for (int k = 1; k <= S + 2; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (irq !== (k == S + 2)) begin
            errors++; $display("FAIL irq_latency edge %0d got %b want %b", k, irq, k == S + 2);
         end
      end
      bus_read(3, v);
      checks++; if (v !== 32'(m_cap)) begin errors++; $display("FAIL latency_cap got %h want %h", v, m_cap); end
   endtask

   task automatic test_clear();
      logic [31:0] v;
      bus_write(3, 32'h0);
      bus_read(3, v);
      checks++; if (v !== 32'h01) begin errors++; $display("FAIL clear_zero got %h want 01", v); end
      bus_write(3, 32'h1); m_cap = 0;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clear_irq got %b want 0", irq); end
      bus_read(3, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL clear_cap got %h want 0", v); end
   endtask

   task automatic test_set_wins();
      logic [31:0] v;
      set_pin(m_pin & ~8'h08);
      repeat (S) @(posedge clk);
      bus_write(3, 32'h08);
      bus_read(3, v);
      checks++; if (v !== 32'h08) begin errors++; $display("FAIL set_wins got %h want 08", v); end
      bus_write(3, 32'h08); m_cap = 0;
      bus_read(3, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL set_wins_clear got %h want 0", v); end
   endtask

   task automatic test_mask();
      logic [31:0] v;
      bus_write(2, 32'h0); m_mask = 0;
      set_pin(m_pin & ~8'h10);
      settle();
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_off_irq got %b want 0", irq); end
      bus_read(3, v);
      checks++; if (v !== 32'h10) begin errors++; $display("FAIL mask_cap got %h want 10", v); end
      bus_write(2, 32'h10);
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mask_on_irq got %b want 1", irq); end
      bus_write(2, 32'h0);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_reoff_irq got %b want 0", irq); end
      bus_write(3, 32'hFF); m_cap = 0;
   endtask

   task automatic test_random();
      logic [31:0] v, d;
      repeat (40) begin
         set_pin(W'($urandom));
         settle();
         d = $urandom;
         case ($urandom_range(0, 3))
            0: begin bus_write(3, d); m_cap = m_cap & ~d[W-1:0]; end
            1: begin bus_write(2, d); m_mask = d[W-1:0]; end
            2: bus_write(2'($urandom_range(0, 1)), d);
            default: ;
         endcase
         checks++; if (irq !== |(m_cap & m_mask)) begin errors++; $display("FAIL rand_irq got %b want %b", irq, |(m_cap & m_mask)); end
         bus_read(0, v);
         checks++; if (v !== 32'(m_pin)) begin errors++; $display("FAIL rand_data got %h want %h", v, m_pin); end
         bus_read(1, v);
         checks++; if (v !== 32'h0) begin errors++; $display("FAIL rand_rsvd got %h want 0", v); end
         bus_read(2, v);
         checks++; if (v !== 32'(m_mask)) begin errors++; $display("FAIL rand_mask got %h want %h", v, m_mask); end
         bus_read(3, v);
         checks++; if (v !== 32'(m_cap)) begin errors++; $display("FAIL rand_cap got %h want %h", v, m_cap); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] v;
      set_pin(8'hFF);
      settle();
      bus_write(3, 32'hFF); m_cap = 0;
      bus_write(2, 32'hFF); m_mask = 8'hFF;
      set_pin(8'h00);
      settle();
      bus_read(3, v);
      checks++; if (v !== 32'hFF) begin errors++; $display("FAIL mid_cap got %h want ff", v); end
      checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mid_irq got %b want 1", irq); end
      @(negedge clk);
      reset_n = 0;
      #1;
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got %b want 0", irq); end
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL mid_reset_rd got %h want 0", readdata); end
      @(posedge clk);
      #1 reset_n = 1;
      m_cap = 0; m_mask = 0;
      settle();
      bus_read(2, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_mask got %h want 0", v); end
      bus_read(3, v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_cap_after got %h want 0", v); end
   endtask

   initial begin
      m_pin = 0; m_cap = 0; m_mask = 0;
      test_reset();
      test_irq_latency();
      test_clear();
      test_set_wins();
      test_mask();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/nios_v1_key_pio.md
NIOS_V1_KEY_PIO -- requirements
Module: nios_v1_key_pio

Interface
REQ-001 Parameter WIDTH, default 8: number of input port bits (1..32).
REQ-002 Parameter EDGE_TYPE, default 1: capture edge; 0 = rising, 1 = falling, 2 = any.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer flops on in_port (2..3).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  slave select; qualifies read and write.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous external inputs (push buttons/switches).
REQ-011 readdata  output  32  read data, registered.
REQ-012 irq  output  1  active-high level interrupt to the processor.

Function
REQ-013 Register map SHALL be: addr 0 DATA (RO, synchronized in_port); addr 1 reserved (reads 0, writes ignored); addr 2 IRQMASK (RW, WIDTH bits); addr 3 EDGECAP (read; write-1-to-clear).
REQ-014 in_port SHALL pass through SYNC_STAGES flops, plus one delay flop for edge detection; all compares use synchronized values only.
REQ-015 Edge SHALL be detected per bit: rising = sync & ~dly; falling = ~sync & dly; any = sync ^ dly.
REQ-016 A detected edge SHALL set the EDGECAP bit on the next clk; the bit holds until cleared.
REQ-017 Write to addr 3 (chipselect & ~write_n) SHALL clear every EDGECAP bit whose writedata bit is 1; other bits unchanged.
REQ-018 Edge detected on a bit in the same cycle as its clear SHALL leave the bit set (set wins).
REQ-019 Write to addr 2 SHALL load IRQMASK from writedata[WIDTH-1:0] on the next clk.
REQ-020 Writes to addr 0/1 SHALL have no effect.
REQ-021 Read (chipselect & write_n) SHALL register the selected register zero-extended to 32 bits into readdata; readdata valid the cycle after address is presented (read latency 1).
REQ-022 readdata SHALL update only on reads; holds its value otherwise.
REQ-023 irq SHALL equal OR over (EDGECAP & IRQMASK), driven from registers, no combinational path from bus inputs.
REQ-024 Latency pin edge -> irq SHALL be SYNC_STAGES+1 clk (SYNC_STAGES+2 from the edge at the pin for the delay flop); masking/unmasking affects irq the cycle after the write.
REQ-025 Bits above WIDTH-1 in readdata SHALL always read 0; writedata bits above WIDTH-1 ignored.

Reset
REQ-026 On reset_n low, asynchronously: sync and delay flops, EDGECAP, IRQMASK, readdata SHALL be 0; irq SHALL be 0.
REQ-027 After reset release, first edge detection SHALL not fire spuriously for falling/any mode: delay flop SHALL be loaded from sync value for the first SYNC_STAGES+1 cycles (edge detect gated until synchronizer primed).
REQ-028 Reset asserted mid-operation SHALL discard pending captures and mask settings.

Structure
REQ-029 Shared package SHALL hold register address constants (DATA=0, IRQMASK=2, EDGECAP=3) and EDGE_TYPE encodings.
REQ-030 One sub-module pio_edge_detect (synchronizer + delay flop + edge pulse, parameterised WIDTH, EDGE_TYPE, SYNC_STAGES) SHALL be instantiated; register file and bus decode stay in top.
REQ-031 Target 120-250 lines RTL total.

Verification
REQ-032 Reset, then read addr 0/2/3 with in_port=8'hFF -> readdata 0x000000FF, 0x0, 0x0; irq=0; no capture after reset release.
REQ-033 IRQMASK=0x01, drive in_port[0] 1->0 (EDGE_TYPE=1) -> EDGECAP=0x01, irq=1 exactly SYNC_STAGES+2 clk after pin edge.
REQ-034 Write 0x01 to addr 3 -> EDGECAP=0x00, irq=0 next cycle; write 0x00 to addr 3 leaves set bits intact.
REQ-035 Falling edge on bit 3 coincident with clear write 0x08 -> EDGECAP bit 3 remains 1.
REQ-036 EDGECAP=0x10, IRQMASK=0x00 -> irq=0; write IRQMASK=0x10 -> irq=1 next cycle; write 0x00 -> irq=0.
REQ-037 Assert reset_n low with EDGECAP=0xFF, IRQMASK=0xFF -> both 0 and irq=0 immediately (asynchronous), readdata=0.
